axi_mem_responder: RTL and testbench

AXI4 subordinate endpoint that terminates the request/response struct interface in an internal word-addressed memory. It is the responder end of the AXI path, downstream of the channel FIFOs. It accepts AW/W/AR, performs FIXED/INCR bursts against local storage, and returns B/R responses. It serves as the default subordinate in UVM benches and as a scratch RAM next to the UART register block.

---
 rtl/axi_mem_responder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 subordinate terminating the request/response structs
// in a word-addressed local memory. FIXED/INCR bursts are served; WRAP and the
// reserved encoding consume their beats and answer SLVERR.
// Optional build macro: AXI_MEM_RESPONDER_ZERO_INIT_EN clears the whole memory
// on every reset edge; without it the storage has no reset at all.

package axi_mem_responder_pkg;
  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 32;
  localparam int unsigned AxiIdWidth   = 4;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } axi_ax_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
  } axi_w_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } axi_b_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   ar_ready;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_t;
endpackage

module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = AxiAddrWidth,
  parameter int unsigned DataWidth = AxiDataWidth,
  parameter int unsigned MemDepth  = 256
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffW      = $clog2(StrbWidth);
  localparam int unsigned IdxW      = AddrWidth - OffW;
  localparam int unsigned MemAw     = $clog2(MemDepth);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;
  localparam logic [1:0] BurstIncr  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [DataWidth-1:0] mem [MemDepth];

  // The word index is never truncated: any set bit above the memory range is a miss.
  function automatic logic in_range(input logic [IdxW-1:0] idx);
    return (idx[IdxW-1:MemAw] == '0);
  endfunction

  // INCR wraps naturally on the full word-index width; FIXED holds the index.
  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx, input logic [1:0] burst);
    return (burst == BurstIncr) ? idx + IdxW'(1) : idx;
  endfunction

  // WRAP and the reserved encoding share bit 1.
  function automatic logic burst_err(input logic [1:0] burst);
    return burst[1];
  endfunction

  logic rst_q;
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic aw_hs, w_hs, ar_hs, r_hs;

  logic [AxiIdWidth-1:0] w_id_q, r_id_q;
  logic [IdxW-1:0]       w_idx_q, r_idx_q, r_load_idx;
  logic [7:0]            w_len_q, w_cnt_q, r_len_q, r_cnt_q;
  logic [1:0]            w_burst_q, r_burst_q, r_load_burst, r_resp_q;
  logic                  w_decerr_q, w_slverr_q, w_last_beat, r_last, r_load_en, mem_we;
  logic [DataWidth-1:0]  r_data_q;
  logic                  unused_bits;

  assign unused_bits = ^{slv_req_i.aw.size, slv_req_i.ar.size,
                         slv_req_i.aw.addr[OffW-1:0], slv_req_i.ar.addr[OffW-1:0]};

  // Readies stay low for the cycle that follows a reset edge.
  always_ff @(posedge clk_i) rst_q <= rst_i;

  // Write FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) w_state_q <= W_IDLE;
    else       w_state_q <= w_state_d;
  end

  assign w_last_beat = (w_cnt_q == w_len_q);

  // Write FSM next state and channel handshake signals.
  always_comb begin
    w_state_d = w_state_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        aw_ready = !rst_q;
        if (!rst_q && slv_req_i.aw_valid) w_state_d = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (slv_req_i.w_valid && w_last_beat) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (slv_req_i.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign aw_hs  = aw_ready & slv_req_i.aw_valid;
  assign w_hs   = w_ready & slv_req_i.w_valid;
  assign mem_we = w_hs && !burst_err(w_burst_q) && in_range(w_idx_q) && !rst_i;

  // Write burst context: captured on AW, advanced and error-flagged per W beat.
  always_ff @(posedge clk_i) begin
    if (aw_hs) begin
      w_id_q     <= slv_req_i.aw.id;
      w_idx_q    <= slv_req_i.aw.addr[AddrWidth-1:OffW];
      w_len_q    <= slv_req_i.aw.len;
      w_burst_q  <= slv_req_i.aw.burst;
      w_cnt_q    <= 8'd0;
      w_decerr_q <= 1'b0;
      w_slverr_q <= burst_err(slv_req_i.aw.burst);
    end else if (w_hs) begin
      w_cnt_q <= w_cnt_q + 8'd1;
      w_idx_q <= next_idx(w_idx_q, w_burst_q);
      if (!in_range(w_idx_q)) w_decerr_q <= 1'b1;
      if (slv_req_i.w.last != w_last_beat) w_slverr_q <= 1'b1;
    end
  end

  // Storage: byte-strobed writes, optional clear on reset.
  always_ff @(posedge clk_i) begin
`ifdef AXI_MEM_RESPONDER_ZERO_INIT_EN
    if (rst_i) begin
      for (int i = 0; i < MemDepth; i++) mem[MemAw'(i)] <= '0;
    end else if (mem_we) begin
      for (int k = 0; k < StrbWidth; k++)
        if (slv_req_i.w.strb[k]) mem[w_idx_q[MemAw-1:0]][8*k +: 8] <= slv_req_i.w.data[8*k +: 8];
    end
`else
    if (mem_we) begin
      for (int k = 0; k < StrbWidth; k++)
        if (slv_req_i.w.strb[k]) mem[w_idx_q[MemAw-1:0]][8*k +: 8] <= slv_req_i.w.data[8*k +: 8];
    end
`endif
  end

  // Read FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

  assign r_last = (r_cnt_q == r_len_q);

  // Read FSM next state and channel handshake signals.
  always_comb begin
    r_state_d = r_state_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready = !rst_q;
        if (!rst_q && slv_req_i.ar_valid) r_state_d = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (slv_req_i.r_ready && r_last) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign ar_hs        = ar_ready & slv_req_i.ar_valid;
  assign r_hs         = r_valid & slv_req_i.r_ready;
  assign r_load_en    = ar_hs | (r_hs & !r_last);
  assign r_load_idx   = ar_hs ? slv_req_i.ar.addr[AddrWidth-1:OffW] : next_idx(r_idx_q, r_burst_q);
  assign r_load_burst = ar_hs ? slv_req_i.ar.burst : r_burst_q;

  // Read burst context and the registered beat; loads see pre-write memory contents.
  always_ff @(posedge clk_i) begin
    if (ar_hs) begin
      r_id_q    <= slv_req_i.ar.id;
      r_len_q   <= slv_req_i.ar.len;
      r_burst_q <= slv_req_i.ar.burst;
      r_cnt_q   <= 8'd0;
    end else if (r_hs) begin
      r_cnt_q <= r_cnt_q + 8'd1;
    end
    if (r_load_en) begin
      r_idx_q <= r_load_idx;
      if (burst_err(r_load_burst)) begin
        r_data_q <= '0;
        r_resp_q <= RespSlverr;
      end else if (!in_range(r_load_idx)) begin
        r_data_q <= '0;
        r_resp_q <= RespDecerr;
      end else begin
        r_data_q <= mem[r_load_idx[MemAw-1:0]];
        r_resp_q <= RespOkay;
      end
    end
  end

  // Response struct assembly.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b_valid  = b_valid;
    slv_resp_o.b.id     = w_id_q;
    slv_resp_o.b.resp   = w_slverr_q ? RespSlverr : (w_decerr_q ? RespDecerr : RespOkay);
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.r_valid  = r_valid;
    slv_resp_o.r.id     = r_id_q;
    slv_resp_o.r.data   = r_data_q;
    slv_resp_o.r.resp   = r_resp_q;
    slv_resp_o.r.last   = r_last;
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: drivers push expected B/R responses
// from a word-array reference model; a negedge monitor pops and compares.
module tb_axi_mem_responder;
  import axi_mem_responder_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  axi_req_t  req;
  axi_resp_t resp;

  axi_mem_responder dut (.clk_i(clk), .rst_i(rst), .slv_req_i(req), .slv_resp_o(resp));

  always #5 clk = ~clk;

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  int checks = 0, errors = 0;
  int b_seen = 0, r_seen = 0;
  logic [31:0] mem_m [256];
  b_exp_t b_q[$];
  r_exp_t r_q[$];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  b_exp_t be;
  r_exp_t re;
  logic        r_stall = 1'b0;
  logic [31:0] r_hold;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned beat_idx(input int unsigned idx0, input int i, input logic [1:0] burst);
    if (burst == 2'b00) return idx0;
    return (idx0 + i) & 32'h3FFF_FFFF;
  endfunction

  // Waits for a ready/valid then returns just after the handshake edge.
  task automatic wait_hs(input int sel, input string name);
    logic ok;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); #1;
      case (sel)
        0: ok = resp.aw_ready;
        1: ok = resp.w_ready;
        2: ok = resp.b_valid;
        default: ok = resp.ar_ready;
      endcase
      if (ok === 1'b1) begin
        @(posedge clk); #1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL timeout %s: got no handshake expected one within 300 cycles", name);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input int err_beat, input int bstall);
    int unsigned idx0 = addr >> 2;
    int unsigned ix;
    logic slv = burst[1] || (err_beat >= 0);
    logic dec = 1'b0;
    for (int i = 0; i <= len; i++) begin
      ix = beat_idx(idx0, i, burst);
      if (!burst[1]) begin
        if (ix < 256) begin
          for (int k = 0; k < 4; k++) if (ws[i][k]) mem_m[ix][8*k +: 8] = wd[i][8*k +: 8];
        end else dec = 1'b1;
      end
    end
    b_q.push_back('{id, slv ? 2'b10 : (dec ? 2'b11 : 2'b00)});
    req.aw.id = id; req.aw.addr = addr; req.aw.len = 8'(len); req.aw.size = 3'd2; req.aw.burst = burst;
    req.aw_valid = 1'b1;
    wait_hs(0, "aw");
    req.aw_valid = 1'b0;
    check("w_ready after AW", resp.w_ready, 1);
    for (int i = 0; i <= len; i++) begin
      req.w.data = wd[i]; req.w.strb = ws[i];
      req.w.last = (i == len) ^ (i == err_beat);
      req.w_valid = 1'b1;
      wait_hs(1, "w");
    end
    req.w_valid = 1'b0;
    check("b_valid after last W", resp.b_valid, 1);
    for (int i = 0; i < bstall; i++) begin @(posedge clk); #1; end
    req.b_ready = 1'b1;
    wait_hs(2, "b");
    req.b_ready = 1'b0;
    check("aw_ready after B", resp.aw_ready, 1);
  endtask

  task automatic push_read(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
    int unsigned ix;
    for (int i = 0; i <= len; i++) begin
      ix = beat_idx(addr >> 2, i, burst);
      if (burst[1])      r_q.push_back('{id, 32'h0, 2'b10, i == len});
      else if (ix > 255) r_q.push_back('{id, 32'h0, 2'b11, i == len});
      else               r_q.push_back('{id, mem_m[ix], 2'b00, i == len});
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input int mode);
    int tgt;
    push_read(id, addr, len, burst);
    tgt = r_seen + len + 1;
    req.ar.id = id; req.ar.addr = addr; req.ar.len = 8'(len); req.ar.size = 3'd2; req.ar.burst = burst;
    req.ar_valid = 1'b1;
    wait_hs(3, "ar");
    req.ar_valid = 1'b0;
    check("r_valid after AR", resp.r_valid, 1);
    for (int cyc = 0; cyc < 600; cyc++) begin
      req.r_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      if (r_seen >= tgt) begin
        @(posedge clk); #1;
        req.r_ready = 1'b0;
        check("ar_ready after last R", resp.ar_ready, 1);
        check("r_valid after last R", resp.r_valid, 0);
        return;
      end
      @(posedge clk); #1;
    end
    req.r_ready = 1'b0;
    checks++; errors++;
    $display("FAIL timeout r beats: got %0d expected %0d", r_seen, tgt);
  endtask

  task automatic model_reset();
    b_q.delete();
    r_q.delete();
`ifdef AXI_MEM_RESPONDER_ZERO_INIT_EN
    foreach (mem_m[i]) mem_m[i] = 32'h0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req.aw_valid = 0; req.w_valid = 0; req.ar_valid = 0; req.b_ready = 0; req.r_ready = 0;
    model_reset();
    @(posedge clk); #1;
    check("reset aw_ready", resp.aw_ready, 0);
    check("reset ar_ready", resp.ar_ready, 0);
    check("reset w_ready", resp.w_ready, 0);
    check("reset b_valid", resp.b_valid, 0);
    check("reset r_valid", resp.r_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("aw_ready after reset", resp.aw_ready, 1);
    check("ar_ready after reset", resp.ar_ready, 1);
  endtask

  // Monitor: scoreboard pops on every handshake, plus channel invariants.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("aw_ready/w_ready exclusive", resp.aw_ready & resp.w_ready, 0);
      check("ar_ready/r_valid exclusive", resp.ar_ready & resp.r_valid, 0);
      if (resp.b_valid && req.b_ready) begin
        b_seen++;
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected B: got id %0h expected none", resp.b.id);
        end else begin
          be = b_q.pop_front();
          check("b.id", resp.b.id, be.id);
          check("b.resp", resp.b.resp, be.resp);
        end
      end
      if (r_stall && resp.r_valid) check("r.data stable in stall", resp.r.data, r_hold);
      if (resp.r_valid && req.r_ready) begin
        r_seen++;
        if (r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected R: got data %0h expected none", resp.r.data);
        end else begin
          re = r_q.pop_front();
          check("r.id", resp.r.id, re.id);
          check("r.data", resp.r.data, re.data);
          check("r.resp", resp.r.resp, re.resp);
          check("r.last", resp.r.last, re.last);
        end
      end
      r_stall = resp.r_valid && !req.r_ready;
      r_hold  = resp.r.data;
    end else begin
      r_stall = 1'b0;
    end
  end

  initial begin
    int tgt, len, bsel, asel, eb;
    logic [1:0] burst;
    int unsigned idx;
    req = '0;
    do_reset();

    // Fill the whole memory so every later read has a defined expectation.
    for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'h1, 32'h0, 255, 2'b01, -1, 0);

    // Single write then read.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(4'h3, 32'h10, 0, 2'b01, -1, 0);
    do_read(4'h5, 32'h10, 0, 2'b01, 0);

    // INCR burst with stalled read-back.
    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    do_write(4'h2, 32'h0, 3, 2'b01, -1, 2);
    do_read(4'h6, 32'h0, 3, 2'b01, 1);

    // Strobes with a FIXED burst.
    wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
    do_write(4'h4, 32'h20, 0, 2'b01, -1, 0);
    wd[0] = 32'h00000011; ws[0] = 4'h1;
    wd[1] = 32'h22000000; ws[1] = 4'h8;
    do_write(4'h4, 32'h20, 1, 2'b00, -1, 0);
    do_read(4'h7, 32'h20, 0, 2'b01, 0);

    // Out-of-range write, then check nothing aliased into word 0.
    wd[0] = 32'hFFFF0000; ws[0] = 4'hF;
    do_write(4'h8, 32'h400, 0, 2'b01, -1, 0);
    do_read(4'h9, 32'h400, 0, 2'b01, 0);
    do_read(4'h9, 32'h0, 0, 2'b01, 0);

    // WRAP read, early last, and an INCR read that wraps the index space.
    do_read(4'hA, 32'h10, 1, 2'b10, 0);
    wd[0] = 32'h12345678; wd[1] = 32'h9ABCDEF0; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(4'hB, 32'h40, 1, 2'b01, 0, 1);
    do_read(4'hC, 32'h40, 1, 2'b01, 2);
    do_read(4'hD, 32'hFFFF_FFF8, 3, 2'b01, 0);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      bsel = $urandom_range(0, 9);
      burst = (bsel < 5) ? 2'b01 : (bsel < 8) ? 2'b00 : (bsel == 8) ? 2'b10 : 2'b11;
      len = $urandom_range(0, 7);
      asel = $urandom_range(0, 9);
      idx = (asel < 7) ? $urandom_range(0, 255) : (asel == 7) ? $urandom_range(250, 255) :
            (asel == 8) ? $urandom_range(32'h3FFF_FFFD, 32'h3FFF_FFFF) : $urandom_range(300, 1000);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        eb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
        do_write(4'($urandom), (idx << 2) | 32'($urandom_range(0, 3)), len, burst, eb, $urandom_range(0, 3));
      end else begin
        do_read(4'($urandom), (idx << 2) | 32'($urandom_range(0, 3)), len, burst, $urandom_range(0, 2));
      end
    end

    // Reset during beat 2 of a len 7 read.
    push_read(4'hE, 32'h80, 7, 2'b01);
    tgt = r_seen + 2;
    req.ar.id = 4'hE; req.ar.addr = 32'h80; req.ar.len = 8'd7; req.ar.size = 3'd2; req.ar.burst = 2'b01;
    req.ar_valid = 1'b1;
    wait_hs(3, "ar reset test");
    req.ar_valid = 1'b0;
    req.r_ready = 1'b1;
    for (int t = 0; t < 50 && r_seen < tgt; t++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    check("beat 2 present before reset", resp.r_valid, 1);
    check("beat 2 data", resp.r.data, mem_m[34]);
    req.r_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("r_valid after mid-burst reset", resp.r_valid, 0);
    check("ar_ready during reset", resp.ar_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ar_ready after release", resp.ar_ready, 1);
    check("aw_ready after release", resp.aw_ready, 1);
    check("b_valid after release", resp.b_valid, 0);
    req.r_ready = 1'b1; req.b_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    req.r_ready = 1'b0; req.b_ready = 1'b0;
    do_read(4'h3, 32'h80, 1, 2'b01, 0);

`ifdef AXI_MEM_RESPONDER_ZERO_INIT_EN
    wd[0] = 32'h55; ws[0] = 4'hF;
    do_write(4'h1, 32'h4, 0, 2'b01, -1, 0);
    do_reset();
    do_read(4'h2, 32'h4, 0, 2'b01, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("B queue drained", b_q.size(), 0);
    check("R queue drained", r_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
